// File: rtl/act_unit_arbiter.sv
// act_unit_arbiter
//   Round-robin arbiter that shares one activation unit (ReLU / sigmoid)
//   among NUM_REQ neuron requesters. The accepted operand and mode are
//   registered toward the unit. A tag pipeline follows the unit's fixed
//   latency so that each result is written into an output FIFO together
//   with its requester id. Credit-based issue means results are never
//   dropped and act_y_i never needs back-pressure.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   req_valid_i     per-requester request valid
//   req_ready_o     one-hot accept (all zero when out of credit)
//   req_data_i      flattened accumulators, 2*DATA_WIDTH each
//   req_sel_i       per-requester mode (0 = ReLU, 1 = sigmoid)
//   act_x_o         registered operand to the activation unit
//   act_sel_o       registered mode to the activation unit
//   act_y_i         activation unit result, ACT_LATENCY after act_x_o
//   out_valid_o     FIFO head valid
//   out_ready_i     downstream ready
//   out_data_o      FIFO head result
//   out_id_o        FIFO head originating requester
//   stall_cnt_o     only with ACT_UNIT_ARBITER_STATS_EN: count of cycles
//                   lost to credit exhaustion (saturating)
//
// Build option: define ACT_UNIT_ARBITER_STATS_EN to add stall_cnt_o.

module act_unit_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACT_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]              req_sel_i,
  output logic [2*DATA_WIDTH-1:0]         act_x_o,
  output logic                            act_sel_o,
  input  logic [DATA_WIDTH-1:0]           act_y_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic [ID_WIDTH-1:0]             out_id_o
`ifdef ACT_UNIT_ARBITER_STATS_EN
  ,
  output logic [31:0]                     stall_cnt_o
`endif
);

  localparam int XW = 2 * DATA_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  // wide enough for fifo_count + inflight_count, each bounded by FIFO_DEPTH
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  localparam int EW = ID_WIDTH + DATA_WIDTH;

  logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [XW-1:0]             act_x_q;
  logic                      act_sel_q;
  logic [ACT_LATENCY:0]      tag_v_q;
  logic [ID_WIDTH-1:0]       tag_id_q [ACT_LATENCY+1];
  logic [EW-1:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]             infl_q, infl_d;

  logic [NUM_REQ-1:0]        gnt;
  logic [PW-1:0]             gnt_idx;
  logic [PW-1:0]             idx;
  logic                      found;
  logic                      credit_ok;
  logic                      accept;
  logic                      wb;
  logic                      pop;

  assign credit_ok = (fifo_cnt_q + infl_q) < CW'(FIFO_DEPTH);

  // Round-robin search starting at the pointer; the grant is suppressed
  // entirely when no credit is left.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
    if (!credit_ok) begin
      gnt = '0;
    end
  end

  assign req_ready_o = gnt;
  assign accept      = |gnt;
  assign wb          = tag_v_q[ACT_LATENCY];
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(wb) - CW'(pop);
    infl_d     = infl_q + CW'(accept) - CW'(wb);
    if (accept) begin
      rr_ptr_d = PW'((int'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      act_x_q    <= '0;
      act_sel_q  <= 1'b0;
      tag_v_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      infl_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      infl_q     <= infl_d;
      if (accept) begin
        act_x_q   <= req_data_i[int'(gnt_idx)*XW +: XW];
        act_sel_q <= req_sel_i[gnt_idx];
      end
      for (int i = ACT_LATENCY; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
      end
      tag_v_q[0] <= accept;
      if (wb) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by tag_v_q and
  // fifo_cnt_q.
  always_ff @(posedge clk_i) begin
    for (int i = ACT_LATENCY; i > 0; i--) begin
      tag_id_q[i] <= tag_id_q[i-1];
    end
    tag_id_q[0] <= ID_WIDTH'(gnt_idx);
    if (wb) begin
      mem_q[wr_ptr_q] <= {tag_id_q[ACT_LATENCY], act_y_i};
    end
  end

  assign act_x_o                = act_x_q;
  assign act_sel_o              = act_sel_q;
  assign out_valid_o            = (fifo_cnt_q != '0);
  assign {out_id_o, out_data_o} = mem_q[rd_ptr_q];

`ifdef ACT_UNIT_ARBITER_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (|req_valid_i && !credit_ok && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // statistics counter not built
`endif

endmodule

// File: tb/tb_act_unit_arbiter.sv
// tb_act_unit_arbiter
//   Directed bench for act_unit_arbiter with NUM_REQ=4, DATA_WIDTH=16,
//   ACT_LATENCY=1, FIFO_DEPTH=4. A registered activation-unit model drives
//   act_y_i. A cycle reference model predicts grants, credit, operand
//   registers and FIFO contents; expected results are queued at grant time
//   and compared when the DUT pops them.

module tb_act_unit_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [3:0]   req_sel;
  logic [31:0]  act_x;
  logic         act_sel;
  logic [15:0]  act_y;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic [1:0]   out_id;
`ifdef ACT_UNIT_ARBITER_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  act_unit_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(16), .ACT_LATENCY(1), .FIFO_DEPTH(4), .ID_WIDTH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_sel_i(req_sel),
    .act_x_o(act_x), .act_sel_o(act_sel), .act_y_i(act_y),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_id_o(out_id)
`ifdef ACT_UNIT_ARBITER_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ReLU saturating to the positive signed 16-bit range; sigmoid stand-in
  // is an arbitrary fixed mapping of the operand.
  function automatic logic [15:0] act_model(input logic [31:0] x, input logic s);
    if (s) return x[23:8] ^ 16'h5A5A;
    if (x[31]) return 16'h0000;
    if (x > 32'h0000_7FFF) return 16'h7FFF;
    return x[15:0];
  endfunction

  always @(posedge clk) act_y <= act_model(act_x, act_sel);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [17:0] sb[$];
  int          m_fcnt = 0;
  logic [1:0]  m_tv   = '0;
  int          m_ptr  = 0;
  logic [31:0] m_actx = '0;
  logic        m_acts = 1'b0;
  logic [31:0] m_stall = '0;
  int          dut_acc = 0;
  int          dut_pop = 0;

  always @(negedge clk) begin
    logic [3:0]  eg;
    int          eid;
    int          k;
    logic        found;
    logic        credit;
    logic        pop;
    logic [17:0] e;
    if (rst) begin
      sb.delete();
      m_fcnt = 0; m_tv = '0; m_ptr = 0;
      m_actx = '0; m_acts = 1'b0; m_stall = '0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_fcnt != 0));
      chk("act_x", 64'(act_x), 64'(m_actx));
      chk("act_sel", 64'(act_sel), 64'(m_acts));
`ifdef ACT_UNIT_ARBITER_STATS_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
      pop = (m_fcnt != 0) && out_ready;
      if (pop && sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_id", 64'(out_id), 64'(e[17:16]));
        chk("out_data", 64'(out_data), 64'(e[15:0]));
      end
      if (out_valid && out_ready) dut_pop++;
      if (|(req_ready & req_valid)) dut_acc++;

      credit = (m_fcnt + int'(m_tv[0]) + int'(m_tv[1])) < 4;
      eg = '0; eid = 0; found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (!found && req_valid[k]) begin
          found = 1'b1; eid = k;
        end
      end
      if (found && credit) eg[eid] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(eg));

      if (pop) m_fcnt--;
      if (m_tv[1]) m_fcnt++;
      m_tv = {m_tv[0], |eg};
      if (|eg) begin
        m_actx = req_data[eid*32 +: 32];
        m_acts = req_sel[eid];
        sb.push_back({2'(eid), act_model(m_actx, m_acts)});
        m_ptr = (eid + 1) % 4;
      end
      if (|req_valid && !credit && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_sel  = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input string tag);
    int i;
    req_valid = '0;
    out_ready = 1'b1;
    i = 0;
    while (sb.size() != 0 && i < 60) begin
      step();
      i++;
    end
    repeat (2) step();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int a0;
    int p0;
    int i;
    rst = 1'b1; req_valid = '0; req_data = '0; req_sel = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_act_x", 64'(act_x), 64'd0);
    chk("rst_act_sel", 64'(act_sel), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // single request from requester 2
    step();
    req_valid = 4'b0100;
    req_sel   = 4'b0000;
    req_data[95:64] = 32'h0001_2345;
    #1 chk("single_gnt", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    chk("single_act_x", 64'(act_x), 64'h0001_2345);
    step();
    step();
    chk("single_out_valid", 64'(out_valid), 64'd1);
    chk("single_out_id", 64'(out_id), 64'd2);
    chk("single_out_data", 64'(out_data), 64'h7FFF);
    drain("single_drain");

    // all requesters continuously valid, no back-pressure
    req_valid = 4'hF;
    a0 = dut_acc;
    repeat (16) step();
    chk("rr_no_bubble", 64'(dut_acc - a0), 64'd16);
    drain("rr_drain");

    // back-pressure: exactly FIFO_DEPTH accepts
    out_ready = 1'b0;
    req_valid = 4'hF;
    a0 = dut_acc;
    repeat (10) step();
    chk("bp_accepts", 64'(dut_acc - a0), 64'd4);
    chk("bp_ready_zero", 64'(req_ready), 64'd0);
    p0 = dut_pop;
    drain("bp_drain");
    chk("bp_results", 64'(dut_pop - p0), 64'd4);

    // full FIFO with toggling downstream ready
    out_ready = 1'b0;
    req_valid = 4'hF;
    repeat (6) step();
    for (int c = 0; c < 24; c++) begin
      out_ready = c[0];
      step();
    end
    drain("full_drain");

    // mid-operation reset with 3 buffered and 1 in flight
    out_ready = 1'b0;
    req_valid = 4'hF;
    i = 0;
    while (!(m_fcnt == 3 && (int'(m_tv[0]) + int'(m_tv[1])) == 1) && i < 20) begin
      step();
      i++;
    end
    chk("mid_rst_setup", 64'(i < 20), 64'd1);
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    req_valid = 4'hF;
    #1 chk("mid_rst_first_gnt", 64'(req_ready), 64'h1);
    out_ready = 1'b1;
    repeat (6) step();
    drain("mid_rst_drain");

    // mixed random traffic
    for (int c = 0; c < 60; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain("rand_drain");

`ifdef ACT_UNIT_ARBITER_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    req_valid = 4'b0011;
    repeat (10) step();
    chk("stall_count", 64'(stall_cnt), 64'd6);
    drain("stall_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/act_unit_arbiter.md
Name: act_unit_arbiter

Overview:
- Shares one activation datapath among NUM_REQ neuron requesters. The shared datapath is a registered ReLU with saturation plus a registered sigmoid LUT.
- Arbitration is round-robin. The block drives the unit's input and mode select, and tracks the unit's fixed result latency with a tag pipeline.
- Results are buffered in an output FIFO with the requester ID attached.
- It sits between the neuron accumulators and the layer writeback logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 16, activation output width; the accumulator is 2*DATA_WIDTH.
- ACT_LATENCY, 1, cycles from act_x_o/act_sel_o registered to act_y_i valid.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least ACT_LATENCY+2).
- ID_WIDTH, 2, requester tag width; must satisfy 2**ID_WIDTH >= NUM_REQ.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  one-hot grant/accept; request k is accepted when req_valid_i[k] and req_ready_o[k] are both high
- req_data_i  in  NUM_REQ*2*DATA_WIDTH  accumulators, flattened, requester k at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH]
- req_sel_i  in  NUM_REQ  per-requester mode: 0=ReLU, 1=sigmoid
- act_x_o  out  2*DATA_WIDTH  registered operand to the activation unit
- act_sel_o  out  1  registered mode to the activation unit
- act_y_i  in  DATA_WIDTH  activation unit result
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DATA_WIDTH  result
- out_id_o  out  ID_WIDTH  originating requester

Behaviour:
- Reset (rst_i high at a clock edge):
  - req_ready_o=0, act_x_o=0, act_sel_o=0, out_valid_o=0.
  - RR pointer=0, in-flight count=0, FIFO empty, tag pipeline valids=0.
  - Reset mid-operation discards in-flight and buffered results; there is no recovery.
- Credit rule: a grant is permitted only when fifo_count + inflight_count < FIFO_DEPTH.
  - inflight_count counts issued operations whose results have not yet been written.
  - Results can therefore never be dropped, and act_y_i is never back-pressured.
- Arbitration (combinational req_ready_o, one-hot or zero):
  - Search starts at the RR pointer: the first k with req_valid_i[k], wrapping modulo NUM_REQ.
  - After an accept, the pointer becomes (granted+1) mod NUM_REQ. With no accept the pointer holds.
  - req_ready_o is 0 for every requester when credit is exhausted.
  - req_ready_o may depend on req_valid_i; requesters must not make valid depend on ready.
- Issue, in the cycle after accept (T+1):
  - act_x_o = accepted req_data_i; act_sel_o = accepted req_sel_i.
  - A tag {valid, id} enters a shift pipeline of length ACT_LATENCY+1.
  - Without an accept, act_x_o and act_sel_o hold their previous value and the tag valid=0.
- Writeback:
  - When the tag at the pipeline end is valid (cycle T+1+ACT_LATENCY), {act_y_i, id} is written to the FIFO.
  - inflight_count decrements in the same cycle.
  - Throughput is one result per cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count.
  - out_valid_o = (count != 0); the head is presented combinationally from storage.
  - Pop occurs when out_valid_o && out_ready_i.
  - Simultaneous push and pop leaves the count unchanged and is legal when full, because credit guarantees no push-when-full without a pop.
  - Push into an empty FIFO makes out_valid_o high the next cycle.
- Ordering: results leave in grant order; ordering between requesters follows RR grant order.
- Counters: simultaneous grant and writeback leaves inflight_count unchanged.

Optional Feature:
- Macro: ACT_UNIT_ARBITER_STATS_EN.
- When defined, add output stall_cnt_o (32 bits), reset to 0.
  - It increments in every cycle where |req_valid_i is high and no grant occurs due to credit exhaustion.
  - It saturates at 0xFFFFFFFF.
- When undefined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Single request, NUM_REQ=4, ACT_LATENCY=1:
  - Stimulus: req 2 valid, data=0x0001_2345, sel=0, out_ready_i=1.
  - Required: ready[2]=1 at T; act_x_o=0x00012345 at T+1; out_valid_o=1 with out_id_o=2 at T+3, out_data_o equal to the act_y_i model value.
- All 4 requesters continuously valid, out_ready_i=1:
  - Required: grants in order 0,1,2,3,0,1… with one accept per cycle and no bubbles after fill.
- Back-pressure, FIFO_DEPTH=4:
  - Stimulus: all requesters valid, out_ready_i=0.
  - Required: exactly 4 accepts, then req_ready_o=0 continuously; no result lost.
  - Then raise out_ready_i and receive the 4 results in grant order.
- Full FIFO with continuous traffic:
  - Stimulus: FIFO full, out_ready_i toggling 1/0.
  - Required: push and pop coincide with count staying at most 4; ids match the grant log.
- Mid-operation reset:
  - Stimulus: assert rst_i for 1 cycle with 3 results buffered and 1 in flight.
  - Required: next cycle out_valid_o=0 and req_ready_o=0; a new request from requester 0 is granted first.
- STATS_EN defined, out_ready_i=0, 2 requesters valid for 10 cycles:
  - Required: stall_cnt_o = 10 − 4 accepts − pipeline fill cycles, matching the reference model exactly.
